// File: rtl/hazard_unit_param_if.sv
// Bundle of pipeline hazard signals shared between the datapath and the hazard unit.
// The master drives the pipeline status; the slave returns stall/flush/forward controls.
interface hazard_unit_param_if #(
    parameter int REG_AW = 5
) ();
    logic              RegWriteE;
    logic              RegWriteM;
    logic              RegWriteW;
    logic              ResultSrcE;
    logic              PcSrcE;
    logic              McValidE;
    logic              McDoneE;
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [REG_AW-1:0] Rs1E;
    logic [REG_AW-1:0] Rs2E;
    logic [REG_AW-1:0] RdE;
    logic [REG_AW-1:0] RdM;
    logic [REG_AW-1:0] RdW;
    logic              stallF;
    logic              stallD;
    logic              stallE;
    logic              FlushD;
    logic              FlushE;
    logic              FlushM;
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic              McTimeout;

    modport master (
        output RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PcSrcE, McValidE, McDoneE,
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  stallF, stallD, stallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE, McTimeout
    );

    modport slave (
        input  RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PcSrcE, McValidE, McDoneE,
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output stallF, stallD, stallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE, McTimeout
    );
endinterface

// File: rtl/hazard_unit_param.sv
// Hazard controller for the 5-stage pipeline: M/W forwarding, load-use stalls of
// configurable length, and multicycle E-unit stalls with a sticky busy-timeout flag.
module hazard_unit_param #(
    parameter int REG_AW         = 5,
    parameter int LOAD_STALL_CYC = 2,
    parameter int MC_TIMEOUT     = 64
) (
    input logic                 clk,
    input logic                 reset,
    hazard_unit_param_if.slave  hz
);
    localparam int MCW = (MC_TIMEOUT > 0) ? $clog2(MC_TIMEOUT + 1) : 1;
    localparam logic [MCW-1:0] MC_LIMIT    = MCW'(MC_TIMEOUT);
    localparam logic [MCW-1:0] MC_MAX      = '1;
    localparam logic [2:0]     LOAD_RELOAD = 3'(LOAD_STALL_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        LSTALL,
        MCBUSY
    } state_t;

    state_t         state;
    state_t         stateNext;
    logic [2:0]     lcnt;
    logic [2:0]     lcntNext;
    logic [MCW-1:0] mccnt;
    logic [MCW-1:0] mccntNext;
    logic           timeout;
    logic           timeoutSet;

    logic lwHit;
    logic mcBusy;
    logic stallF, stallD, stallE, flushD, flushE, flushM;
    logic [1:0] fwdA, fwdB;

    // RegWriteE is part of the pipeline bundle but forwarding never looks at E.
    logic unused_regwrite_e;
    assign unused_regwrite_e = hz.RegWriteE;

    assign lwHit  = hz.ResultSrcE && (hz.RdE != '0) &&
                    ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
    assign mcBusy = hz.McValidE && !hz.McDoneE;

    always_comb begin
        fwdA = 2'b00;
        fwdB = 2'b00;
        if (hz.RegWriteM && (hz.Rs1E != '0) && (hz.Rs1E == hz.RdM))
            fwdA = 2'b10;
        else if (hz.RegWriteW && (hz.Rs1E != '0) && (hz.Rs1E == hz.RdW))
            fwdA = 2'b01;
        if (hz.RegWriteM && (hz.Rs2E != '0) && (hz.Rs2E == hz.RdM))
            fwdB = 2'b10;
        else if (hz.RegWriteW && (hz.Rs2E != '0) && (hz.Rs2E == hz.RdW))
            fwdB = 2'b01;
    end

    // Priority in IDLE: multicycle busy, then taken branch, then load-use.
    always_comb begin
        stateNext  = state;
        lcntNext   = lcnt;
        mccntNext  = mccnt;
        timeoutSet = 1'b0;
        stallF     = 1'b0;
        stallD     = 1'b0;
        stallE     = 1'b0;
        flushD     = 1'b0;
        flushE     = 1'b0;
        flushM     = 1'b0;
        case (state)
            IDLE: begin
                if (mcBusy) begin
                    stallF    = 1'b1;
                    stallD    = 1'b1;
                    stallE    = 1'b1;
                    flushM    = 1'b1;
                    mccntNext = MCW'(1);
                    stateNext = MCBUSY;
                end else if (hz.PcSrcE) begin
                    flushD = 1'b1;
                    flushE = 1'b1;
                end else if (lwHit) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                    if (LOAD_STALL_CYC > 1) begin
                        lcntNext  = LOAD_RELOAD;
                        stateNext = LSTALL;
                    end
                end
            end
            LSTALL: begin
                if (hz.PcSrcE) begin
                    flushD    = 1'b1;
                    flushE    = 1'b1;
                    lcntNext  = 3'd0;
                    stateNext = IDLE;
                end else begin
                    stallF   = 1'b1;
                    stallD   = 1'b1;
                    flushE   = 1'b1;
                    lcntNext = lcnt - 3'd1;
                    if (lcnt == 3'd1)
                        stateNext = IDLE;
                end
            end
            MCBUSY: begin
                if (mcBusy) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    flushM = 1'b1;
                    if (mccnt != MC_MAX)
                        mccntNext = mccnt + MCW'(1);
                end else begin
                    mccntNext = '0;
                    stateNext = IDLE;
                    if (hz.PcSrcE) begin
                        flushD = 1'b1;
                        flushE = 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
        // mccntNext counts busy cycles completed, so the flag rises right after the limit-th one.
        if ((MC_TIMEOUT != 0) && stallE && (mccntNext == MC_LIMIT))
            timeoutSet = 1'b1;
    end

    // State, counters and the sticky timeout flag; reset drops any stall in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lcnt    <= 3'd0;
            mccnt   <= '0;
            timeout <= 1'b0;
        end else begin
            state <= stateNext;
            lcnt  <= lcntNext;
            mccnt <= mccntNext;
            if (timeoutSet)
                timeout <= 1'b1;
        end
    end

    // Outputs are forced low for as long as reset is held, not just after the edge.
    always_comb begin
        hz.stallF    = stallF && !reset;
        hz.stallD    = stallD && !reset;
        hz.stallE    = stallE && !reset;
        hz.FlushD    = flushD && !reset;
        hz.FlushE    = flushE && !reset;
        hz.FlushM    = flushM && !reset;
        hz.ForwardAE = reset ? 2'b00 : fwdA;
        hz.ForwardBE = reset ? 2'b00 : fwdB;
        hz.McTimeout = timeout && !reset;
    end
endmodule
